n_accum: RTL and testbench



---
 rtl/n_accum_pkg.sv | 36 +++
 rtl/n_adder.sv | 16 +
 rtl/n_accum.sv | 93 +++++++++
 tb/tb_n_accum.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/n_accum_pkg.sv
// n_accum_pkg: shared types and range helpers for the n_accum group summer.
// Helpers work on 64-bit signed values so any N/ACC_W up to 64 can use them.
package n_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Clamp a wide signed value into the signed n-bit range.
  function automatic logic signed [63:0] sat_n(
    input logic signed [63:0] v,
    input int n
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // High when a wide signed value does not fit in signed n bits.
  function automatic logic ovf_n(
    input logic signed [63:0] v,
    input int n
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/n_adder.sv
// n_adder: plain N-bit adder with carry in and carry out.
// Shared datapath block, used here at the accumulator width.
module n_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  // Widen by one bit so the carry falls out of the top.
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + (N+1)'(c_in);

endmodule

// File: rtl/n_accum.sv
// n_accum: sums groups of LEN signed samples, emits one N-bit result per group.
// Define N_ACCUM_SAT_EN to saturate out_sum; default build wraps.
module n_accum
  import n_accum_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CNT_W = $clog2(LEN);
  localparam int ACC_W = N + $clog2(LEN);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W-1:0]   nxt;
  logic signed [63:0] nxt64;
  logic [N-1:0]       sum_d;
  logic               ovf_d;
  logic               last;

  assign ext   = {{(ACC_W-N){in_data[N-1]}}, in_data};
  assign nxt64 = {{(64-ACC_W){nxt[ACC_W-1]}}, nxt};
  assign last  = (cnt == CNT_W'(LEN - 1));

  n_adder #(.N(ACC_W)) u_add (
    .a     (acc),
    .b     (ext),
    .c_in  (1'b0),
    .sum   (nxt),
    .c_out ()
  );

  // Handshake flags decode straight from the state.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // Result formatting for the completing sample.
  always_comb begin
    ovf_d = ovf_n(nxt64, N);
`ifdef N_ACCUM_SAT_EN
    sum_d = N'(sat_n(nxt64, N));
`else
    sum_d = nxt[N-1:0];
`endif
  end

  // Accumulate, close the group, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      unique case (1'b1)
        in_ready: begin
          if (in_valid) begin
            acc <= nxt;
            if (last) begin
              cnt     <= '0;
              state   <= HOLD;
              out_sum <= sum_d;
              out_ovf <= ovf_d;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        out_valid: begin
          if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n_accum.sv
// tb_n_accum: directed and scoreboarded checks of n_accum at N=8, LEN=4.
// Expected sums follow N_ACCUM_SAT_EN when it is defined.
module tb_n_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  n_accum #(.N(8), .LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sum_s();
    return int'($signed(out_sum));
  endfunction

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic send(input int s);
    int n;
    logic [31:0] v;
    v = s;
    in_data  = v[7:0];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_group(input string tag, input int s0, input int s1,
                           input int s2, input int s3, input int esum,
                           input int eovf, input bit gaps);
    int s[4];
    s = '{s0, s1, s2, s3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      if (gaps && i < 3) begin
        check({tag, "_gap_nv"}, int'(out_valid), 0);
        tick();
      end
    end
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_rdy_lo"}, int'(in_ready), 0);
    check({tag, "_sum"}, sum_s(), esum);
    check({tag, "_ovf"}, int'(out_ovf), eovf);
    tick();
    check({tag, "_rdy_hi"}, int'(in_ready), 1);
    check({tag, "_vld_lo"}, int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s[4];
    int tot;
    int es;
    int eo;
    logic [31:0] tv;
    logic [7:0] r;

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    rst = 1'b0;
    tick();

    run_group("g35", 5, 10, 30, -10, 35, 0, 1'b0);
`ifdef N_ACCUM_SAT_EN
    run_group("gpos", 127, 127, 127, 127, 127, 1, 1'b0);
    run_group("gneg", -128, -128, -128, -128, -128, 1, 1'b0);
`else
    run_group("gpos", 127, 127, 127, 127, -4, 1, 1'b0);
    run_group("gneg", -128, -128, -128, -128, 0, 1, 1'b0);
`endif

    out_ready = 1'b0;
    send(5);
    send(10);
    send(30);
    send(-10);
    in_data  = 8'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_sum", sum_s(), 35);
      check("bp_rdy", int'(in_ready), 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", int'(out_valid), 0);
    run_group("bp_next", 1, 2, 3, 4, 10, 0, 1'b0);

    send(100);
    send(100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rdy", int'(in_ready), 1);
    check("mid_rst_vld", int'(out_valid), 0);
    check("mid_rst_sum", int'(out_sum), 0);
    run_group("after_rst", 1, 2, 3, 4, 10, 0, 1'b0);

    run_group("gaps", 1, -1, 2, -2, 0, 0, 1'b1);

    for (int g = 0; g < 10; g++) begin
      tot = 0;
      for (int i = 0; i < 4; i++) begin
        r = 8'($urandom_range(0, 255));
        s[i] = int'($signed(r));
        tot += s[i];
      end
      eo = (tot > 127 || tot < -128) ? 1 : 0;
`ifdef N_ACCUM_SAT_EN
      es = (tot > 127) ? 127 : (tot < -128) ? -128 : tot;
`else
      tv = tot;
      es = int'($signed(tv[7:0]));
`endif
      run_group($sformatf("rnd%0d", g), s[0], s[1], s[2], s[3], es, eo, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
